// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM CPU program sequencer: opcode constants,
// the sequencer state encoding and the default program-counter width.
package hrm_pkg;

  localparam int unsigned PC_W_DEFAULT = 12;

  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_JUMPZ = 4'h9;
  localparam logic [3:0] OP_JUMPN = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT,
    ST_FAULT
  } seq_state_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Issue handshake between the program sequencer and the ALU/memory datapath.
//   valid : instruction presented (sequencer -> datapath)
//   op    : registered opcode
//   data  : registered signed operand
//   ready : datapath accepts/completes the presented instruction
interface program_sequencer_if;
  logic               valid;
  logic [3:0]         op;
  logic signed [11:0] data;
  logic               ready;

  modport master (output valid, output op, output data, input ready);
  modport slave  (input valid, input op, input data, output ready);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC and jump-target check.
//   pc          : current program counter
//   op, data    : instruction being decoded
//   acc_zero/neg: accumulator flags for conditional jumps
//   next_pc     : jump target when taken, otherwise pc+1
//   take_jump   : op is a jump whose condition holds
//   bad_target  : operand is negative or >= SIZE
//   end_of_prog : pc is the last legal address (SIZE-1)
module pc_next
  import hrm_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT,
  parameter int unsigned SIZE = 6
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [3:0]       op,
  input  logic signed [11:0] data,
  input  logic             acc_zero,
  input  logic             acc_neg,
  output logic [PC_W-1:0]  next_pc,
  output logic             take_jump,
  output logic             bad_target,
  output logic             end_of_prog
);

  logic [31:0] data_u;

  always_comb begin
    data_u      = 32'(unsigned'(data));
    take_jump   = (op == OP_JUMP) ||
                  ((op == OP_JUMPZ) && acc_zero) ||
                  ((op == OP_JUMPN) && acc_neg);
    bad_target  = data[11] || (data_u >= SIZE);
    end_of_prog = (pc == PC_W'(SIZE - 1));
    next_pc     = take_jump ? data[PC_W-1:0] : pc + PC_W'(1);
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/issue controller for the HRM program ROM. Owns the PC, resolves
// JUMP/JUMPZ/JUMPN/HALT internally and issues all other instructions to the
// datapath over a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : start request (IDLE and HALT only)
//   pc                : ROM address
//   rom_op, rom_data  : ROM outputs
//   ex                : issue handshake to the datapath
//   acc_zero, acc_neg : accumulator flags from the datapath
//   halted, fault     : program finished / illegal jump target
//   retired           : completed-instruction count, saturating
module program_sequencer
  import hrm_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT,
  parameter int unsigned SIZE = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic [PC_W-1:0]     pc,
  input  logic [3:0]          rom_op,
  input  logic signed [11:0]  rom_data,
  program_sequencer_if.master ex,
  input  logic                acc_zero,
  input  logic                acc_neg,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         retired
);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [3:0]         op_q, op_d;
  logic signed [11:0] data_q, data_d;
  logic [15:0]        retired_q;
  logic               retire;

  logic [3:0]         dec_op;
  logic [PC_W-1:0]    next_pc;
  logic               take_jump, bad_target, end_of_prog;

  // Decode the live ROM word while fetching; in ISSUE the held opcode is a
  // datapath op, so next_pc collapses to pc+1.
  assign dec_op = (state_q == ST_FETCH) ? rom_op : op_q;

  pc_next #(
    .PC_W (PC_W),
    .SIZE (SIZE)
  ) u_pc_next (
    .pc          (pc_q),
    .op          (dec_op),
    .data        (rom_data),
    .acc_zero    (acc_zero),
    .acc_neg     (acc_neg),
    .next_pc     (next_pc),
    .take_jump   (take_jump),
    .bad_target  (bad_target),
    .end_of_prog (end_of_prog)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      op_q      <= '0;
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      data_q  <= data_d;
      if (retire && (retired_q != '1)) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    data_d  = data_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        op_d   = rom_op;
        data_d = rom_data;
        if (rom_op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (rom_op inside {OP_JUMP, OP_JUMPZ, OP_JUMPN}) begin
          if (take_jump && bad_target) begin
            state_d = ST_FAULT;
          end else begin
            retire = 1'b1;
            if (!take_jump && end_of_prog) state_d = ST_HALT;
            else                           pc_d    = next_pc;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ex.ready) begin
          retire = 1'b1;
          if (end_of_prog) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (run) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FAULT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc       = pc_q;
  assign ex.valid = (state_q == ST_ISSUE);
  assign ex.op    = op_q;
  assign ex.data  = data_q;
  assign halted   = (state_q == ST_HALT);
  assign fault    = (state_q == ST_FAULT);
  assign retired  = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam logic [3:0] OP_OUT   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_JUMPZ = 4'h9;
  localparam logic [3:0] OP_JUMPN = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic [11:0]        pc;
  logic [3:0]         rom_op;
  logic signed [11:0] rom_data;
  logic               acc_zero, acc_neg;
  logic               halted, fault;
  logic [15:0]        retired;

  logic [3:0]         op_mem   [16];
  logic signed [11:0] data_mem [16];

  int checks   = 0;
  int failures = 0;

  program_sequencer_if ex_bus ();

  program_sequencer #(
    .PC_W (12),
    .SIZE (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .pc       (pc),
    .rom_op   (rom_op),
    .rom_data (rom_data),
    .ex       (ex_bus),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  assign rom_op   = op_mem[pc[3:0]];
  assign rom_data = data_mem[pc[3:0]];

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) begin
      op_mem[i]   = 4'h0;
      data_mem[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ex_bus.ready = 1'b0;
    acc_zero = 1'b0; acc_neg = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse run for one cycle; returns at the negedge of the first FETCH cycle.
  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    @(negedge clk);
    checks++; if (pc !== 12'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (ex_bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_bus.valid); end
    checks++; if (ex_bus.op !== 4'h0 || ex_bus.data !== 12'sd0) begin failures++; $display("FAIL reset_exreg got=%h/%0d exp=0/0", ex_bus.op, ex_bus.data); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", halted, fault); end
    checks++; if (retired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_basic();
    logic [11:0]        ipc  [8];
    logic [3:0]         iop  [8];
    logic signed [11:0] idat [8];
    int n = 0;
    clear_rom();
    op_mem[0] = OP_ADD; data_mem[0] = 12'sd7;
    op_mem[1] = OP_SUB; data_mem[1] = -12'sd3;
    op_mem[2] = OP_OUT; data_mem[2] = 12'sd0;
    op_mem[3] = OP_HALT;
    do_reset();
    ex_bus.ready = 1'b1;
    start_run();
    for (int i = 0; i < 40 && !halted; i++) begin
      if (ex_bus.valid && n < 8) begin
        ipc[n] = pc; iop[n] = ex_bus.op; idat[n] = ex_bus.data; n++;
      end
      @(negedge clk);
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL basic_issue_count got=%0d exp=3", n); end
    if (n == 3) begin
      checks++; if (ipc[0] !== 12'd0 || ipc[1] !== 12'd1 || ipc[2] !== 12'd2) begin failures++; $display("FAIL basic_issue_pcs got=%0d,%0d,%0d exp=0,1,2", ipc[0], ipc[1], ipc[2]); end
      checks++; if (iop[0] !== OP_ADD || iop[1] !== OP_SUB || iop[2] !== OP_OUT) begin failures++; $display("FAIL basic_issue_ops got=%h,%h,%h exp=3,4,1", iop[0], iop[1], iop[2]); end
      checks++; if (idat[0] !== 12'sd7 || idat[1] !== -12'sd3) begin failures++; $display("FAIL basic_issue_data got=%0d,%0d exp=7,-3", idat[0], idat[1]); end
    end
    checks++; if (halted !== 1'b1 || pc !== 12'd3) begin failures++; $display("FAIL basic_halt got=halted%b pc%0d exp=halted1 pc3", halted, pc); end
    checks++; if (retired !== 16'd3) begin failures++; $display("FAIL basic_retired got=%0d exp=3", retired); end
    checks++; if (ex_bus.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_halt got=%b exp=0", ex_bus.valid); end
  endtask

  task automatic test_stall();
    int found = 0;
    clear_rom();
    op_mem[0] = OP_ADD; data_mem[0] = 12'sd5;
    op_mem[1] = OP_HALT;
    do_reset();
    start_run();
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (ex_bus.valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin failures++; $display("FAIL stall_valid_seen got=%0d exp=1", found); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ex_bus.valid !== 1'b1 || ex_bus.op !== OP_ADD || ex_bus.data !== 12'sd5 || pc !== 12'd0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got=v%b op%h d%0d pc%0d exp=v1 op3 d5 pc0", i, ex_bus.valid, ex_bus.op, ex_bus.data, pc);
      end
      @(negedge clk);
    end
    ex_bus.ready = 1'b1;
    @(negedge clk);
    checks++; if (ex_bus.valid !== 1'b0 || pc !== 12'd1 || retired !== 16'd1) begin failures++; $display("FAIL stall_release got=v%b pc%0d r%0d exp=v0 pc1 r1", ex_bus.valid, pc, retired); end
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL stall_halt got=%b exp=1", halted); end
  endtask

  task automatic test_jumpz();
    int found;
    clear_rom();
    op_mem[0] = OP_ADD;   data_mem[0] = 12'sd1;
    op_mem[1] = OP_SUB;   data_mem[1] = 12'sd1;
    op_mem[2] = OP_JUMPZ; data_mem[2] = 12'sd0;
    op_mem[3] = OP_HALT;
    do_reset();
    acc_zero = 1'b1;
    ex_bus.ready = 1'b1;
    start_run();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (pc == 12'd2 && !ex_bus.valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin failures++; $display("FAIL jumpz_reach_pc2 got=%0d exp=1", found); end
    @(negedge clk);
    checks++; if (pc !== 12'd0 || ex_bus.valid !== 1'b0 || retired !== 16'd3) begin failures++; $display("FAIL jumpz_taken got=pc%0d v%b r%0d exp=pc0 v0 r3", pc, ex_bus.valid, retired); end
    acc_zero = 1'b0;
    @(negedge clk);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (pc == 12'd2 && !ex_bus.valid) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin failures++; $display("FAIL jumpz_reach_pc2_again got=%0d exp=1", found); end
    @(negedge clk);
    checks++; if (pc !== 12'd3 || ex_bus.valid !== 1'b0 || retired !== 16'd6) begin failures++; $display("FAIL jumpz_not_taken got=pc%0d v%b r%0d exp=pc3 v0 r6", pc, ex_bus.valid, retired); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 12'd3 || retired !== 16'd6) begin failures++; $display("FAIL jumpz_halt got=h%b pc%0d r%0d exp=h1 pc3 r6", halted, pc, retired); end
  endtask

  task automatic test_jump_bounds();
    clear_rom();
    op_mem[0] = OP_JUMP;  data_mem[0] = 12'sd5;
    op_mem[5] = OP_JUMPN; data_mem[5] = -12'sd1;
    do_reset();
    acc_neg = 1'b1;
    start_run();
    @(negedge clk);
    checks++; if (pc !== 12'd5 || ex_bus.valid !== 1'b0 || retired !== 16'd1 || fault !== 1'b0) begin failures++; $display("FAIL bounds_jump_last got=pc%0d v%b r%0d f%b exp=pc5 v0 r1 f0", pc, ex_bus.valid, retired, fault); end
    @(negedge clk);
    checks++; if (fault !== 1'b1 || pc !== 12'd5 || retired !== 16'd1) begin failures++; $display("FAIL bounds_negative_target got=f%b pc%0d r%0d exp=f1 pc5 r1", fault, pc, retired); end
    acc_neg = 1'b0;
  endtask

  task automatic test_fault();
    clear_rom();
    op_mem[0] = OP_ADD;  data_mem[0] = 12'sd2;
    op_mem[1] = OP_JUMP; data_mem[1] = 12'sd9;
    do_reset();
    ex_bus.ready = 1'b1;
    start_run();
    for (int i = 0; i < 20 && !fault; i++) @(negedge clk);
    checks++; if (fault !== 1'b1 || pc !== 12'd1) begin failures++; $display("FAIL fault_entry got=f%b pc%0d exp=f1 pc1", fault, pc); end
    checks++; if (retired !== 16'd1 || halted !== 1'b0 || ex_bus.valid !== 1'b0) begin failures++; $display("FAIL fault_outputs got=r%0d h%b v%b exp=r1 h0 v0", retired, halted, ex_bus.valid); end
    run = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fault !== 1'b1 || pc !== 12'd1 || ex_bus.valid !== 1'b0) begin failures++; $display("FAIL fault_sticky_run got=f%b pc%0d v%b exp=f1 pc1 v0", fault, pc, ex_bus.valid); end
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || pc !== 12'd0) begin failures++; $display("FAIL fault_reset got=f%b pc%0d exp=f0 pc0", fault, pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_halt();
    clear_rom();
    for (int i = 0; i < 6; i++) begin
      op_mem[i] = OP_ADD; data_mem[i] = 12'(i);
    end
    do_reset();
    ex_bus.ready = 1'b1;
    start_run();
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    checks++; if (halted !== 1'b1 || pc !== 12'd5 || retired !== 16'd6) begin failures++; $display("FAIL nohalt_end got=h%b pc%0d r%0d exp=h1 pc5 r6", halted, pc, retired); end
    run = 1'b1;
    @(negedge clk);
    checks++; if (halted !== 1'b0 || pc !== 12'd0) begin failures++; $display("FAIL nohalt_restart got=h%b pc%0d exp=h0 pc0", halted, pc); end
    run = 1'b0;
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    checks++; if (halted !== 1'b1 || retired !== 16'd12) begin failures++; $display("FAIL nohalt_second_pass got=h%b r%0d exp=h1 r12", halted, retired); end
  endtask

  task automatic test_reset_mid_issue();
    int found = 0;
    clear_rom();
    op_mem[0] = OP_ADD; data_mem[0] = 12'sd4;
    op_mem[1] = OP_SUB; data_mem[1] = 12'sd8;
    op_mem[2] = OP_HALT;
    do_reset();
    ex_bus.ready = 1'b1;
    start_run();
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ex_bus.valid && pc == 12'd1) found = 1;
      else @(negedge clk);
    end
    ex_bus.ready = 1'b0;
    @(negedge clk);
    checks++; if (found !== 1 || ex_bus.valid !== 1'b1 || retired !== 16'd1 || ex_bus.op !== OP_SUB) begin failures++; $display("FAIL midrst_setup got=found%0d v%b r%0d op%h exp=found1 v1 r1 op4", found, ex_bus.valid, retired, ex_bus.op); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ex_bus.valid !== 1'b0 || pc !== 12'd0 || ex_bus.op !== 4'h0 || ex_bus.data !== 12'sd0) begin failures++; $display("FAIL midrst_async got=v%b pc%0d op%h d%0d exp=v0 pc0 op0 d0", ex_bus.valid, pc, ex_bus.op, ex_bus.data); end
    checks++; if (retired !== 16'd0 || halted !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL midrst_counters got=r%0d h%b f%b exp=r0 h0 f0", retired, halted, fault); end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    ex_bus.ready = 1'b1;
    checks++; if (pc !== 12'd0 || ex_bus.valid !== 1'b0) begin failures++; $display("FAIL midrst_restart_fetch got=pc%0d v%b exp=pc0 v0", pc, ex_bus.valid); end
    @(negedge clk);
    checks++; if (ex_bus.valid !== 1'b1 || pc !== 12'd0 || ex_bus.op !== OP_ADD) begin failures++; $display("FAIL midrst_restart_issue got=v%b pc%0d op%h exp=v1 pc0 op3", ex_bus.valid, pc, ex_bus.op); end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ex_bus.ready = 1'b0;
    acc_zero = 1'b0; acc_neg = 1'b0;
    clear_rom();
    test_reset();
    test_basic();
    test_stall();
    test_jumpz();
    test_jump_bounds();
    test_fault();
    test_no_halt();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
